srcnn_mac_ctrl: RTL and testbench

- Sequences one external srcnn 16ns×16s→32 combinational multiplier instance to compute one convolution output: bias + Σ(pix·wgt) over num_taps beats.
- Followed by rounding shift, optional ReLU and 16-bit saturation.
- Sits between the line-buffer/weight-fetch streams and the output writer, and uses the HLS block-level start/done/idle/ready protocol.

---
 rtl/srcnn_mac_ctrl.sv | 141 ++++++++++++++
 tb/tb_srcnn_mac_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/srcnn_mac_ctrl.sv
// srcnn_mac_ctrl: sequences one external 16x16 multiplier into a bias + sum-of-products
// convolution output with rounding shift, optional ReLU and 16-bit saturation.
module srcnn_mac_ctrl #(
    parameter int MAX_TAPS  = 81,
    parameter int ACC_WIDTH = 40
) (
    input  logic        ap_clk,
    input  logic        ap_rst,
    input  logic        ap_start,
    output logic        ap_done,
    output logic        ap_idle,
    output logic        ap_ready,
    input  logic [6:0]  num_taps,
    input  logic [4:0]  shift,
    input  logic [31:0] bias,
    input  logic        relu_en,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] pix,
    input  logic [15:0] wgt,
    output logic [15:0] mul_din0,
    output logic [15:0] mul_din1,
    input  logic [31:0] mul_dout,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_t;

    localparam logic [6:0] MAX_T = 7'(MAX_TAPS);
    localparam logic signed [ACC_WIDTH:0] SAT_HI = (ACC_WIDTH+1)'(32767);
    localparam logic signed [ACC_WIDTH:0] SAT_LO = -(ACC_WIDTH+1)'(32768);

    state_t                       state_q;
    logic [6:0]                   n_q;
    logic [6:0]                   cnt_q;
    logic [4:0]                   shift_q;
    logic                         relu_q;
    logic signed [ACC_WIDTH-1:0]  acc_q;
    logic [31:0]                  prod_q;
    logic                         prod_vld_q;
    logic                         out_valid_q;
    logic [15:0]                  out_data_q;

    logic [6:0]                   n_eff;
    logic                         beat;
    logic                         last;
    logic signed [ACC_WIDTH-1:0]  bias_ext;
    logic signed [ACC_WIDTH-1:0]  prod_ext;
    logic signed [ACC_WIDTH-1:0]  fin;
    logic signed [ACC_WIDTH:0]    wide;
    logic signed [ACC_WIDTH:0]    half;
    logic signed [ACC_WIDTH:0]    rsum;
    logic signed [ACC_WIDTH:0]    r;
    logic [15:0]                  out_data_d;

    assign n_eff    = (num_taps > MAX_T) ? MAX_T : num_taps;
    assign beat     = (state_q == RUN) && in_valid;
    assign last     = beat && ((cnt_q + 7'd1) == n_q);
    assign bias_ext = {{(ACC_WIDTH-32){bias[31]}}, bias};
    assign prod_ext = {{(ACC_WIDTH-32){prod_q[31]}}, prod_q};

    assign ap_idle  = (state_q == IDLE);
    assign in_ready = (state_q == RUN);
    assign ap_ready = last || (ap_idle && ap_start && (n_eff == 7'd0));
    assign ap_done  = (state_q == OUT) && out_ready;
    assign mul_din0 = in_ready ? pix : 16'd0;
    assign mul_din1 = in_ready ? wgt : 16'd0;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    // Rounding is done one bit wider so the half-LSB add cannot wrap.
    always_comb begin
        fin  = acc_q + (prod_vld_q ? prod_ext : '0);
        wide = {fin[ACC_WIDTH-1], fin};
        half = $signed((ACC_WIDTH+1)'(1) << (shift_q - 5'd1));
        rsum = wide + half;
        r    = wide;
        if (shift_q != 5'd0) r = rsum >>> shift_q;
        if (relu_q && r < 0) r = '0;
        out_data_d = r[15:0];
        if (r > SAT_HI) out_data_d = 16'h7fff;
        else if (r < SAT_LO) out_data_d = 16'h8000;
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q     <= IDLE;
            n_q         <= '0;
            cnt_q       <= '0;
            shift_q     <= '0;
            relu_q      <= 1'b0;
            acc_q       <= '0;
            prod_q      <= '0;
            prod_vld_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (ap_start) begin
                        n_q        <= n_eff;
                        shift_q    <= shift;
                        relu_q     <= relu_en;
                        acc_q      <= bias_ext;
                        cnt_q      <= '0;
                        prod_q     <= '0;
                        prod_vld_q <= 1'b0;
                        state_q    <= (n_eff != 7'd0) ? RUN : DRAIN;
                    end
                end
                RUN: begin
                    if (prod_vld_q) acc_q <= acc_q + prod_ext;
                    if (beat) begin
                        prod_q     <= mul_dout;
                        prod_vld_q <= 1'b1;
                        cnt_q      <= cnt_q + 7'd1;
                        if (last) state_q <= DRAIN;
                    end else begin
                        prod_vld_q <= 1'b0;
                    end
                end
                DRAIN: begin
                    out_data_q  <= out_data_d;
                    out_valid_q <= 1'b1;
                    state_q     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        out_data_q  <= '0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_srcnn_mac_ctrl.sv
// Directed self-checking bench for srcnn_mac_ctrl with a behavioural
// 16u x 16s multiplier attached to the mul_* ports.
module tb_srcnn_mac_ctrl;

    logic        ap_clk = 1'b0;
    logic        ap_rst;
    logic        ap_start;
    logic        ap_done;
    logic        ap_idle;
    logic        ap_ready;
    logic [6:0]  num_taps;
    logic [4:0]  shift;
    logic [31:0] bias;
    logic        relu_en;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] pix;
    logic [15:0] wgt;
    logic [15:0] mul_din0;
    logic [15:0] mul_din1;
    logic [31:0] mul_dout;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;

    logic signed [32:0] mul_prod;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    always #5 ap_clk = ~ap_clk;

    assign mul_prod = $signed({1'b0, mul_din0}) * $signed(mul_din1);
    assign mul_dout = mul_prod[31:0];

    always @(posedge ap_clk) if (ap_done) done_cnt++;

    srcnn_mac_ctrl dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start),
        .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready),
        .num_taps(num_taps), .shift(shift), .bias(bias),
        .relu_en(relu_en), .in_valid(in_valid), .in_ready(in_ready),
        .pix(pix), .wgt(wgt), .mul_din0(mul_din0), .mul_din1(mul_din1),
        .mul_dout(mul_dout), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data)
    );

    // Stimulus helpers: all driving happens on the falling edge.
    task automatic start_job(input logic [6:0] n, input logic [4:0] sh,
                             input logic [31:0] b, input logic r,
                             output logic rdy);
        @(negedge ap_clk);
        ap_start = 1'b1; num_taps = n; shift = sh; bias = b; relu_en = r;
        #1 rdy = ap_ready;
        @(negedge ap_clk);
        ap_start = 1'b0;
    endtask

    task automatic beat(input logic [15:0] p, input logic [15:0] w,
                        output logic acc, output logic rdy);
        in_valid = 1'b1; pix = p; wgt = w;
        #1 acc = in_ready; rdy = ap_ready;
        @(negedge ap_clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = -1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (out_valid) begin
                cyc = i;
                break;
            end
            @(negedge ap_clk);
        end
    endtask

    task automatic handshake(output logic d);
        out_ready = 1'b1;
        #1 d = ap_done;
        @(negedge ap_clk);
        out_ready = 1'b0;
    endtask

    // One-beat job: returns result, cycles from last beat to out_valid, ap_done.
    task automatic job1(input logic [4:0] sh, input logic [31:0] b,
                        input logic r, input logic [6:0] n,
                        input logic [15:0] p, input logic [15:0] w,
                        output logic [15:0] res, output int lat);
        logic rdy, acc, d;
        start_job(n, sh, b, r, rdy);
        if (n != 7'd0) beat(p, w, acc, rdy);
        wait_valid(lat);
        res = out_data;
        handshake(d);
    endtask

    task automatic test_reset;
        ap_rst = 1'b1; ap_start = 0; num_taps = 0; shift = 0; bias = 0;
        relu_en = 0; in_valid = 0; pix = 0; wgt = 0; out_ready = 0;
        repeat (3) @(negedge ap_clk);
        ap_rst = 1'b0;
        #1;
        checks++;
        if ({ap_idle, ap_done, ap_ready, in_ready, out_valid} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_flags got %b want 10000",
                     {ap_idle, ap_done, ap_ready, in_ready, out_valid});
        end
        checks++;
        if (out_data !== 16'd0) begin
            errors++;
            $display("FAIL reset_data got %h want 0000", out_data);
        end
    endtask

    task automatic test_basic;
        logic rdy, acc, d;
        logic [15:0] ps [3] = '{16'd1, 16'd2, 16'd3};
        logic [15:0] ws [3] = '{16'd4, -16'sd5, 16'd6};
        start_job(7'd3, 5'd0, 32'd0, 1'b0, rdy);
        checks++;
        if (rdy !== 1'b0) begin
            errors++;
            $display("FAIL basic_start_ready got %b want 0", rdy);
        end
        for (int i = 0; i < 3; i++) begin
            beat(ps[i], ws[i], acc, rdy);
            checks++;
            if (acc !== 1'b1 || rdy !== (i == 2)) begin
                errors++;
                $display("FAIL basic_beat%0d in_ready=%b ap_ready=%b want 1 %b",
                         i, acc, rdy, (i == 2));
            end
        end
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_early_valid got %b want 0", out_valid);
        end
        @(negedge ap_clk); #1;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'd12) begin
            errors++;
            $display("FAIL basic_result valid=%b data=%0d want 1 12",
                     out_valid, $signed(out_data));
        end
        handshake(d);
        checks++;
        if (d !== 1'b1) begin
            errors++;
            $display("FAIL basic_done got %b want 1", d);
        end
        #1;
        checks++;
        if (out_valid !== 1'b0 || ap_idle !== 1'b1 || ap_done !== 1'b0) begin
            errors++;
            $display("FAIL basic_after valid=%b idle=%b done=%b want 0 1 0",
                     out_valid, ap_idle, ap_done);
        end
    endtask

    task automatic test_stalls;
        logic rdy, acc, d;
        int lat, k, d0;
        logic gap [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [15:0] ps [3] = '{16'd1, 16'd2, 16'd3};
        logic [15:0] ws [3] = '{16'd4, -16'sd5, 16'd6};
        d0 = done_cnt;
        start_job(7'd3, 5'd0, 32'd0, 1'b0, rdy);
        k = 0;
        for (int i = 0; i < 6; i++) begin
            if (gap[i]) begin
                beat(ps[k], ws[k], acc, rdy);
                k++;
            end else begin
                @(negedge ap_clk);
            end
        end
        wait_valid(lat);
        checks++;
        if (lat !== 1) begin
            errors++;
            $display("FAIL stall_latency got %0d want 1", lat);
        end
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_data !== 16'd12 || ap_done !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold%0d valid=%b data=%0d done=%b want 1 12 0",
                         i, out_valid, $signed(out_data), ap_done);
            end
            @(negedge ap_clk);
        end
        handshake(d);
        repeat (3) @(negedge ap_clk);
        checks++;
        if (d !== 1'b1 || done_cnt - d0 !== 1) begin
            errors++;
            $display("FAIL stall_done pulse=%b count=%0d want 1 1", d, done_cnt - d0);
        end
    endtask

    task automatic test_saturate;
        logic [15:0] res;
        int lat;
        job1(5'd0, 32'd0, 1'b0, 7'd1, 16'hffff, 16'h7fff, res, lat);
        checks++;
        if (res !== 16'h7fff || lat !== 1) begin
            errors++;
            $display("FAIL sat_high got %h lat %0d want 7fff 1", res, lat);
        end
        job1(5'd0, 32'd0, 1'b0, 7'd1, 16'hffff, 16'h8000, res, lat);
        checks++;
        if (res !== 16'h8000) begin
            errors++;
            $display("FAIL sat_low got %h want 8000", res);
        end
        job1(5'd0, 32'd0, 1'b1, 7'd1, 16'hffff, 16'h8000, res, lat);
        checks++;
        if (res !== 16'h0000) begin
            errors++;
            $display("FAIL sat_relu got %h want 0000", res);
        end
    endtask

    task automatic test_round;
        logic [15:0] res;
        int lat;
        job1(5'd1, 32'd0, 1'b0, 7'd1, 16'd3, 16'd1, res, lat);
        checks++;
        if (res !== 16'd2) begin
            errors++;
            $display("FAIL round_pos got %0d want 2", $signed(res));
        end
        job1(5'd1, 32'd0, 1'b0, 7'd1, 16'd1, -16'sd3, res, lat);
        checks++;
        if (res !== 16'hffff) begin
            errors++;
            $display("FAIL round_neg got %0d want -1", $signed(res));
        end
        job1(5'd2, -32'sd5, 1'b0, 7'd0, 16'd0, 16'd0, res, lat);
        checks++;
        if (res !== 16'hffff) begin
            errors++;
            $display("FAIL round_bias got %0d want -1", $signed(res));
        end
    endtask

    task automatic test_zero_taps;
        logic rdy, d;
        logic bad;
        in_valid = 1'b1; pix = 16'd77; wgt = 16'd9;
        start_job(7'd0, 5'd0, 32'd100, 1'b0, rdy);
        checks++;
        if (rdy !== 1'b1) begin
            errors++;
            $display("FAIL zero_ready got %b want 1", rdy);
        end
        #1;
        bad = (mul_din0 !== 0) || (mul_din1 !== 0) || in_ready || out_valid;
        @(negedge ap_clk); #1;
        bad |= (mul_din0 !== 0) || (mul_din1 !== 0) || in_ready;
        checks++;
        if (bad !== 1'b0 || out_valid !== 1'b1 || out_data !== 16'd100) begin
            errors++;
            $display("FAIL zero_result bad=%b valid=%b data=%0d want 0 1 100",
                     bad, out_valid, $signed(out_data));
        end
        handshake(d);
        in_valid = 1'b0;
    endtask

    task automatic test_max_taps;
        logic rdy, d;
        int n;
        start_job(7'd100, 5'd0, 32'd0, 1'b0, rdy);
        in_valid = 1'b1; pix = 16'd1; wgt = 16'd1;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            #1 if (in_ready) n++;
            @(negedge ap_clk);
        end
        in_valid = 1'b0;
        #1;
        checks++;
        if (n !== 81 || out_valid !== 1'b1 || out_data !== 16'd81) begin
            errors++;
            $display("FAIL max_taps beats=%0d valid=%b data=%0d want 81 1 81",
                     n, out_valid, $signed(out_data));
        end
        handshake(d);
    endtask

    task automatic test_reset_mid;
        logic rdy;
        int d0;
        start_job(7'd100, 5'd0, 32'd0, 1'b0, rdy);
        in_valid = 1'b1; pix = 16'd2; wgt = 16'd3;
        repeat (40) @(negedge ap_clk);
        d0 = done_cnt;
        ap_rst = 1'b1;
        @(negedge ap_clk);
        ap_rst = 1'b0;
        #1;
        checks++;
        if (ap_idle !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset idle=%b in_ready=%b valid=%b want 1 0 0",
                     ap_idle, in_ready, out_valid);
        end
        repeat (5) @(negedge ap_clk);
        in_valid = 1'b0;
        checks++;
        if (done_cnt !== d0 || ap_idle !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_done got %0d dones idle=%b want 0 1",
                     done_cnt - d0, ap_idle);
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_stalls;
        test_saturate;
        test_round;
        test_zero_taps;
        test_max_taps;
        test_reset_mid;
        test_basic;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
